axicb_round_robin_prio: RTL and testbench
=========================================

# axicb_round_robin_prio

Parametrised round-robin arbiter for the AXI crossbar switching and arbitration stages. It supports any requester count, 2^PRIO_W priority layers each with its own rotating mask, and an optional grant lock. With the lock enabled, a winner keeps its grant until the downstream channel signals `release`. It replaces the fixed 4/8-requester non-blocking arbiter wherever prioritised or locked arbitration is needed.

## Interface
- `REQ_NB`, 4, number of requesters; legal range 2..32.
- `PRIO_W`, 2, priority field width per requester; PRIO_NB = 2^PRIO_W layers; 0 is lowest.
- `LOCK`, 1, 1 = hold grant until `release`; 0 = non-blocking, re-arbitrates every cycle.
- `ID_W`, $clog2(REQ_NB), width of `grant_id`.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset: asynchronous, active-low.
- `srst`  in  1  synchronous reset, active-high; same effect as `aresetn`.
- `en`  in  1  grant accepted this cycle; advances the mask and, if LOCK=1, takes the lock.
- `req`  in  REQ_NB  request vector.
- `prio`  in  REQ_NB*PRIO_W  priority of requester i in bits [i*PRIO_W +: PRIO_W].
- `release`  in  1  locked transfer complete; only meaningful in LOCKED.
- `grant`  out  REQ_NB  one-hot grant, or all zero.
- `grant_id`  out  ID_W  binary index of `grant`; 0 when no grant.
- `grant_valid`  out  1  OR-reduction of `grant`.
- `busy`  out  1  high in LOCKED.

## Operation
- **State held:**
  - One mask per layer, `mask[L]`, REQ_NB bits, reset to all ones.
  - FSM state: IDLE or LOCKED, reset to IDLE.
  - `grant_q`, REQ_NB bits, reset to 0.
- **Arbitration in IDLE (combinational):**
  - Lmax = highest `prio` value among requesters with `req`=1.
  - `lvl_req` = `req` restricted to requesters whose priority equals Lmax.
  - `m` = `lvl_req & mask[Lmax]`.
  - If `m`≠0, grant the lowest set index of `m`; otherwise grant the lowest set index of `lvl_req`.
  - No request: `grant`=0, `grant_valid`=0, `grant_id`=0.
- **Mask update** on a clock edge with state IDLE, `en`=1 and `grant_valid`=1, winning index k at layer Lmax:
  - k < REQ_NB-1: `mask[Lmax]` ← bits k+1..REQ_NB-1 set, all others clear.
  - k = REQ_NB-1: `mask[Lmax]` ← all ones (wrap-around).
  - All other layers' masks are unchanged.
- **FSM:**
  - IDLE→LOCKED when LOCK=1, `en`=1 and `grant_valid`=1; `grant_q` ← `grant`.
  - LOCKED: `grant` = `grant_q`, independent of `req`, `prio` and `en`. A locked requester that drops `req` keeps its grant. No mask updates.
  - LOCKED→IDLE on `release`=1; `grant_q` ← 0.
  - `release` in IDLE is ignored.
  - LOCK=0: the FSM stays in IDLE and `busy` is tied to 0.
- **Resets:**
  - `aresetn` low or `srst` high (srst wins over all other events on that edge): masks ← all ones, state ← IDLE, `grant_q` ← 0.
  - Reset mid-lock drops the lock immediately (async) or on the next edge (srst).
- **Output reset values:** `busy`=0. `grant`/`grant_id`/`grant_valid` are the IDLE combinational function of `req` with all masks at ones; with `req`=0 they are 0/0/0.

## Timing
- IDLE: `req`/`prio` → `grant` has zero-cycle latency (combinational). The mask takes effect on the cycle after the accepting edge.
- LOCK=1: grant is accepted at edge N, `busy`=1 from N+1. `release` at edge M: `grant` is still `grant_q` during cycle M; `busy`=0 and fresh arbitration are visible in cycle M+1.
- Minimum lock occupancy is 1 cycle (`release` high in the first LOCKED cycle).
- Back-to-back grants to different requesters with LOCK=1 need at least 2 cycles each.
- LOCK=0: a new grant may be issued every cycle.
- `grant_valid` and `grant_id` are consistent with `grant` in the same cycle.

## Test plan
- **Rotation:** REQ_NB=4, LOCK=0, all prio 0, `req`=1111, `en`=1 for 5 cycles → grants 0001, 0010, 0100, 1000, 0001; `grant_id` 0, 1, 2, 3, 0.
- **Skip and fallback:** `req`=1101 → 0001, 0100, 1000, 0001. Then `req`=0011 → 0010, 0001 (mask 1100 doesn't match, unmasked fallback), 0010.
- **Priority layers:** `req`=1111, prio = {0,2,0,0} (req2 at layer 2), `en`=1 → 0100 repeatedly, and `mask[0]` stays 1111. Drop req2 → 0001, 0010, 1000, 0001, with `mask[0]` rotating independently.
- **Lock:** LOCK=1, `req`=0110, `en` pulse → `grant`=0010, `busy`=1. Drop `req[1]` and hold `release`=0 for 3 cycles → `grant` stays 0010. Assert `release` → next cycle `busy`=0, `grant`=0100.
- **Reset mid-lock:** while LOCKED, assert `srst` for 1 cycle → next cycle `busy`=0 and masks all ones; `req`=1111 → 0001. Repeat with an async `aresetn` pulse between edges → `busy` drops immediately.
- **Wide config:** REQ_NB=32, PRIO_W=1, random `req`/`prio` with `en` random → scoreboard model check: one-hot grant, highest layer wins, no starvation within 32 accepted grants per layer.

Source files
------------

// File: rtl/axicb_round_robin_prio_if.sv
// Request/grant bundle between the arbiter and its requesters/downstream channel.
// lock_release is the downstream "locked transfer complete" strobe.
interface axicb_round_robin_prio_if #(
    parameter int REQ_NB = 4,
    parameter int PRIO_W = 2,
    parameter int ID_W   = $clog2(REQ_NB)
);
    logic                     en;
    logic [REQ_NB-1:0]        req;
    logic [REQ_NB*PRIO_W-1:0] prio;
    logic                     lock_release;
    logic [REQ_NB-1:0]        grant;
    logic [ID_W-1:0]          grant_id;
    logic                     grant_valid;
    logic                     busy;

    modport master (
        output en, req, prio, lock_release,
        input  grant, grant_id, grant_valid, busy
    );

    modport slave (
        input  en, req, prio, lock_release,
        output grant, grant_id, grant_valid, busy
    );
endinterface

// File: rtl/axicb_round_robin_prio.sv
// Round-robin arbiter with 2^PRIO_W priority layers, a rotating mask per layer,
// and an optional grant lock held until the downstream channel releases it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | combinational arbitration; accepted grants rotate the mask
// ST_LOCKED | grant frozen at r_grant_q until lock_release (LOCK=1 only)
module axicb_round_robin_prio #(
    parameter int REQ_NB = 4,
    parameter int PRIO_W = 2,
    parameter bit LOCK   = 1'b1,
    parameter int ID_W   = $clog2(REQ_NB)
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_srst,
    axicb_round_robin_prio_if.slave bus
);
    localparam int PRIO_NB = 1 << PRIO_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [REQ_NB-1:0] r_mask [PRIO_NB];
    logic [REQ_NB-1:0] r_grant_q;
    logic [REQ_NB-1:0] w_grant_q_nxt;

    logic [PRIO_W-1:0] w_lmax;
    logic [REQ_NB-1:0] w_lvl_req;
    logic [REQ_NB-1:0] w_masked;
    logic [REQ_NB-1:0] w_arb_grant;
    logic [ID_W-1:0]   w_arb_id;
    logic              w_arb_valid;
    logic [REQ_NB-1:0] w_mask_nxt;
    logic              w_mask_upd;
    logic [REQ_NB-1:0] w_grant;
    logic [ID_W-1:0]   w_grant_id;

    always_comb begin : arbitrate
        w_lmax = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            if (bus.req[i] && (bus.prio[i*PRIO_W +: PRIO_W] > w_lmax))
                w_lmax = bus.prio[i*PRIO_W +: PRIO_W];
        end

        w_lvl_req = '0;
        for (int i = 0; i < REQ_NB; i++)
            w_lvl_req[i] = bus.req[i] && (bus.prio[i*PRIO_W +: PRIO_W] == w_lmax);

        w_masked = w_lvl_req & r_mask[w_lmax];

        // Scan downwards so the lowest qualifying index is the last one written.
        w_arb_grant = '0;
        w_arb_id    = '0;
        for (int i = REQ_NB - 1; i >= 0; i--) begin
            if ((w_masked != '0) ? w_masked[i] : w_lvl_req[i]) begin
                w_arb_grant    = '0;
                w_arb_grant[i] = 1'b1;
                w_arb_id       = ID_W'(i);
            end
        end
        w_arb_valid = |w_arb_grant;

        w_mask_nxt = '0;
        for (int j = 0; j < REQ_NB; j++)
            w_mask_nxt[j] = (j > int'(w_arb_id)) || (int'(w_arb_id) == REQ_NB - 1);
    end

    always_comb begin : fsm_next
        w_state_nxt   = r_state;
        w_grant_q_nxt = r_grant_q;
        w_mask_upd    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.en && w_arb_valid) begin
                    w_mask_upd = 1'b1;
                    if (LOCK) begin
                        w_state_nxt   = ST_LOCKED;
                        w_grant_q_nxt = w_arb_grant;
                    end
                end
            end
            ST_LOCKED: begin
                if (bus.lock_release) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_q_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_grant_q_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin : fsm_reg
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_grant_q <= '0;
        end else if (i_srst) begin
            r_state   <= ST_IDLE;
            r_grant_q <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant_q <= w_grant_q_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin : mask_reg
        if (!aresetn) begin
            for (int l = 0; l < PRIO_NB; l++)
                r_mask[l] <= '1;
        end else if (i_srst) begin
            for (int l = 0; l < PRIO_NB; l++)
                r_mask[l] <= '1;
        end else if (w_mask_upd) begin
            r_mask[w_lmax] <= w_mask_nxt;
        end
    end

    assign w_grant = (r_state == ST_LOCKED) ? r_grant_q : w_arb_grant;

    always_comb begin : encode_id
        w_grant_id = '0;
        for (int i = 0; i < REQ_NB; i++)
            if (w_grant[i]) w_grant_id = ID_W'(i);
    end

    assign bus.grant       = w_grant;
    assign bus.grant_id    = w_grant_id;
    assign bus.grant_valid = |w_grant;
    assign bus.busy        = LOCK && (r_state == ST_LOCKED);
endmodule

// File: tb/tb_axicb_round_robin_prio.sv
// Bench for axicb_round_robin_prio: non-blocking, locked and 32-requester instances,
// expected outputs queued per driven cycle and compared once outputs settle.
module tb_axicb_round_robin_prio;
    logic aclk = 1'b0;
    logic aresetn;
    logic srst;
    int   checks   = 0;
    int   failures = 0;

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] grant;
        logic [4:0]  id;
        logic        valid;
        logic        busy;
    } obs_t;

    typedef struct {
        logic [3:0] req;
        logic [7:0] prio;
        logic       en;
        logic       rel;
        logic       sr;
        logic [3:0] g;
        logic       busy;
    } step_t;

    obs_t sb_q[$];

    axicb_round_robin_prio_if #(.REQ_NB(4),  .PRIO_W(2)) bus_nb ();
    axicb_round_robin_prio_if #(.REQ_NB(4),  .PRIO_W(2)) bus_lk ();
    axicb_round_robin_prio_if #(.REQ_NB(32), .PRIO_W(1)) bus_w ();

    axicb_round_robin_prio #(.REQ_NB(4), .PRIO_W(2), .LOCK(1'b0)) dut_nb (
        .aclk(aclk), .aresetn(aresetn), .i_srst(srst), .bus(bus_nb.slave));
    axicb_round_robin_prio #(.REQ_NB(4), .PRIO_W(2), .LOCK(1'b1)) dut_lk (
        .aclk(aclk), .aresetn(aresetn), .i_srst(srst), .bus(bus_lk.slave));
    axicb_round_robin_prio #(.REQ_NB(32), .PRIO_W(1), .LOCK(1'b0)) dut_w (
        .aclk(aclk), .aresetn(aresetn), .i_srst(srst), .bus(bus_w.slave));

    function automatic obs_t mk_exp(input logic [31:0] g, input logic b);
        obs_t o;
        o.grant = g;
        o.id    = '0;
        for (int i = 31; i >= 0; i--)
            if (g[i]) o.id = 5'(i);
        o.valid = |g;
        o.busy  = b;
        return o;
    endfunction

    function automatic obs_t obs_nb();
        return {32'(bus_nb.grant), 5'(bus_nb.grant_id), bus_nb.grant_valid, bus_nb.busy};
    endfunction

    function automatic obs_t obs_lk();
        return {32'(bus_lk.grant), 5'(bus_lk.grant_id), bus_lk.grant_valid, bus_lk.busy};
    endfunction

    function automatic obs_t obs_w();
        return {bus_w.grant, bus_w.grant_id, bus_w.grant_valid, bus_w.busy};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("grant=%h id=%0d valid=%b busy=%b", o.grant, o.id, o.valid, o.busy);
    endfunction

    task automatic zero_inputs();
        bus_nb.req = '0; bus_nb.prio = '0; bus_nb.en = 1'b0; bus_nb.lock_release = 1'b0;
        bus_lk.req = '0; bus_lk.prio = '0; bus_lk.en = 1'b0; bus_lk.lock_release = 1'b0;
        bus_w.req  = '0; bus_w.prio  = '0; bus_w.en  = 1'b0; bus_w.lock_release  = 1'b0;
    endtask

    task automatic pulse_srst();
        @(negedge aclk);
        srst = 1'b1;
        zero_inputs();
        @(negedge aclk);
        srst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, want;
        @(negedge aclk);
        #1;
        want = mk_exp(32'h0, 1'b0);
        sb_q.push_back(want);
        got = obs_nb(); want = sb_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL reset_nb actual %s required %s", fmt(got), fmt(want)); end
        sb_q.push_back(mk_exp(32'h0, 1'b0));
        got = obs_lk(); want = sb_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL reset_lk actual %s required %s", fmt(got), fmt(want)); end
        @(negedge aclk);
        bus_lk.req = 4'b1111; bus_lk.en = 1'b1;
        sb_q.push_back(mk_exp(32'h1, 1'b0));
        #1;
        got = obs_lk(); want = sb_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL reset_comb actual %s required %s", fmt(got), fmt(want)); end
        @(negedge aclk);
        aresetn = 1'b1;
        bus_lk.en = 1'b0;
        @(negedge aclk);
        bus_lk.req = 4'b1000;
        sb_q.push_back(mk_exp(32'h8, 1'b0));
        #1;
        got = obs_lk(); want = sb_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL reset_idle actual %s required %s", fmt(got), fmt(want)); end
    endtask

    task automatic test_rotation();
        step_t tbl[$];
        obs_t  got, want;
        pulse_srst();
        tbl.push_back('{4'b1111, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0});
        tbl.push_back('{4'b1111, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0});
        tbl.push_back('{4'b1111, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0});
        tbl.push_back('{4'b1111, 8'h00, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0});
        tbl.push_back('{4'b1111, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge aclk);
            bus_nb.req = tbl[i].req; bus_nb.prio = tbl[i].prio; bus_nb.en = tbl[i].en;
            sb_q.push_back(mk_exp(32'(tbl[i].g), tbl[i].busy));
            #1;
            got = obs_nb(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL rotation[%0d] actual %s required %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_skip_fallback();
        step_t tbl[$];
        obs_t  got, want;
        pulse_srst();
        tbl.push_back('{4'b1101, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0});
        tbl.push_back('{4'b1101, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0});
        tbl.push_back('{4'b1101, 8'h00, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0});
        tbl.push_back('{4'b1101, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0});
        tbl.push_back('{4'b0011, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0});
        tbl.push_back('{4'b0011, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0});
        tbl.push_back('{4'b0011, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge aclk);
            bus_nb.req = tbl[i].req; bus_nb.prio = tbl[i].prio; bus_nb.en = tbl[i].en;
            sb_q.push_back(mk_exp(32'(tbl[i].g), tbl[i].busy));
            #1;
            got = obs_nb(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL skip_fallback[%0d] actual %s required %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_priority();
        step_t tbl[$];
        obs_t  got, want;
        pulse_srst();
        // req2 alone at layer 2
        for (int n = 0; n < 3; n++)
            tbl.push_back('{4'b1111, 8'h20, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0});
        tbl.push_back('{4'b1011, 8'h20, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0});
        tbl.push_back('{4'b1011, 8'h20, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0});
        tbl.push_back('{4'b1011, 8'h20, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0});
        tbl.push_back('{4'b1011, 8'h20, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0});
        // req0 and req3 share layer 3, req1 at layer 1
        tbl.push_back('{4'b1111, 8'hC7, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0});
        tbl.push_back('{4'b1111, 8'hC7, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0});
        tbl.push_back('{4'b1111, 8'hC7, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0});
        tbl.push_back('{4'b1111, 8'hC7, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0});
        tbl.push_back('{4'b1111, 8'hC7, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0});
        tbl.push_back('{4'b1111, 8'hC7, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0});
        tbl.push_back('{4'b1111, 8'hC7, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0});
        tbl.push_back('{4'b0000, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0});
        tbl.push_back('{4'b1111, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge aclk);
            bus_nb.req = tbl[i].req; bus_nb.prio = tbl[i].prio; bus_nb.en = tbl[i].en;
            sb_q.push_back(mk_exp(32'(tbl[i].g), tbl[i].busy));
            #1;
            got = obs_nb(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL priority[%0d] actual %s required %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_lock();
        step_t tbl[$];
        obs_t  got, want;
        pulse_srst();
        tbl.push_back('{4'b0110, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0});
        tbl.push_back('{4'b0100, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1});
        tbl.push_back('{4'b1000, 8'hC0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1});
        tbl.push_back('{4'b0100, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1});
        tbl.push_back('{4'b0100, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1});
        tbl.push_back('{4'b0100, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0});
        tbl.push_back('{4'b0100, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0});
        tbl.push_back('{4'b0100, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0});
        tbl.push_back('{4'b1111, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0});
        tbl.push_back('{4'b1111, 8'h00, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1});
        tbl.push_back('{4'b1111, 8'h00, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0});
        tbl.push_back('{4'b1111, 8'h00, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b1});
        tbl.push_back('{4'b1111, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge aclk);
            bus_lk.req = tbl[i].req; bus_lk.prio = tbl[i].prio;
            bus_lk.en  = tbl[i].en;  bus_lk.lock_release = tbl[i].rel;
            sb_q.push_back(mk_exp(32'(tbl[i].g), tbl[i].busy));
            #1;
            got = obs_lk(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL lock[%0d] actual %s required %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_reset_mid_lock();
        step_t tbl[$];
        obs_t  got, want;
        pulse_srst();
        tbl.push_back('{4'b0010, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0});
        tbl.push_back('{4'b0010, 8'h00, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1});
        tbl.push_back('{4'b1111, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0});
        tbl.push_back('{4'b0010, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0});
        tbl.push_back('{4'b0010, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge aclk);
            bus_lk.req = tbl[i].req; bus_lk.prio = tbl[i].prio;
            bus_lk.en  = tbl[i].en;  bus_lk.lock_release = tbl[i].rel;
            srst = tbl[i].sr;
            sb_q.push_back(mk_exp(32'(tbl[i].g), tbl[i].busy));
            #1;
            got = obs_lk(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL srst_lock[%0d] actual %s required %s", i, fmt(got), fmt(want)); end
        end
        srst = 1'b0;
        // async pulse between edges while LOCKED with mask[0]=1100
        #1;
        aresetn = 1'b0;
        bus_lk.req = 4'b1111;
        sb_q.push_back(mk_exp(32'h1, 1'b0));
        #1;
        got = obs_lk(); want = sb_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL async_lock actual %s required %s", fmt(got), fmt(want)); end
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        sb_q.push_back(mk_exp(32'h1, 1'b0));
        #1;
        got = obs_lk(); want = sb_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL async_after actual %s required %s", fmt(got), fmt(want)); end
    endtask

    task automatic test_wide();
        int          ptr [2];
        int          seen [32];
        logic [31:0] r, p, g, lvl;
        logic        e;
        int          lmax, k;
        obs_t        got, want;
        int          bad;
        pulse_srst();
        ptr[0] = 0; ptr[1] = 0;
        for (int c = 0; c < 500; c++) begin
            r = (c % 3 == 0) ? ($urandom() & $urandom() & $urandom()) : $urandom();
            if (c % 17 == 0) r = '0;
            p = $urandom();
            e = ($urandom_range(0, 3) != 0);
            @(negedge aclk);
            bus_w.req = r; bus_w.prio = p; bus_w.en = e;
            lmax = 0;
            for (int i = 0; i < 32; i++) if (r[i] && p[i]) lmax = 1;
            for (int i = 0; i < 32; i++) lvl[i] = r[i] && (int'(p[i]) == lmax);
            k = -1;
            for (int i = ptr[lmax]; i < 32 && k < 0; i++) if (lvl[i]) k = i;
            for (int i = 0; i < 32 && k < 0; i++) if (lvl[i]) k = i;
            g = (k >= 0) ? (32'd1 << k) : 32'd0;
            sb_q.push_back(mk_exp(g, 1'b0));
            #1;
            got = obs_w(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL wide[%0d] actual %s required %s", c, fmt(got), fmt(want)); end
            if (e && k >= 0) ptr[lmax] = (k + 1) % 32;
        end
        // all requesters on layer 1: 32 accepted grants must visit each exactly once
        for (int i = 0; i < 32; i++) seen[i] = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge aclk);
            bus_w.req = '1; bus_w.prio = '1; bus_w.en = 1'b1;
            #1;
            seen[bus_w.grant_id]++;
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (seen[i] != 1) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL starvation actual %0d requesters not granted once required 0", bad); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual time limit reached required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        srst    = 1'b0;
        zero_inputs();
        test_reset();
        test_rotation();
        test_skip_fallback();
        test_priority();
        test_lock();
        test_reset_mid_lock();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
